// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the shared-ALU arbiter and its clients.
// slave = arbiter side, master = requester/consumer side.
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned OPW = 4;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*OPW-1:0]   req_op;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_result;
    logic                  resp_zero;
    logic                  resp_err;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered-in/registered-out 64-bit ALU among NREQ clients.
// Optional illegal-op reporting on resp_err is enabled by defining ALU_SHARE_OPCHECK_EN.
module alu_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64
) (
    input logic                  clk,
    input logic                  reset,
    alu_share_arbiter_if.slave   bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned OPW = 4;
    localparam int unsigned SW  = IDW + 1;

    localparam logic [OPW-1:0] OP_AND  = 4'b0000;
    localparam logic [OPW-1:0] OP_OR   = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPW-1:0] OP_PASS = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [IDW-1:0]   r_id;
    logic             r_resp_valid;
    logic [IDW-1:0]   r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_zero;
    logic             r_resp_err;

    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt_id;
    logic [NREQ-1:0]  w_gnt_onehot;
    logic [SW-1:0]    w_sum;
    logic [IDW-1:0]   w_cand;
    logic [NREQ-1:0]  w_req_ready;
    logic             w_hs;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_res_zero;
    logic             w_res_err;

    // First valid requester at or after rr_ptr, wrapping NREQ-1 -> 0
    always_comb begin
        w_gnt_found  = 1'b0;
        w_gnt_id     = '0;
        w_sum        = '0;
        w_cand       = '0;
        w_gnt_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum  = SW'(r_rr_ptr) + SW'(k);
            w_cand = (w_sum >= SW'(NREQ)) ? IDW'(w_sum - SW'(NREQ)) : IDW'(w_sum);
            if (!w_gnt_found && bus.req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_cand;
            end
        end
        if (w_gnt_found) begin
            w_gnt_onehot[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = w_gnt_onehot;
                if (w_gnt_found) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (r_op)
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_ADD:  w_alu_res = r_a + r_b;
            OP_SUB:  w_alu_res = r_a - r_b;
            OP_PASS: w_alu_res = r_b;
            default: w_alu_res = '0;
        endcase
    end

`ifdef ALU_SHARE_OPCHECK_EN
    // Illegal ops are flagged and never report zero
    always_comb begin
        w_res_err  = !(r_op == OP_AND || r_op == OP_OR || r_op == OP_ADD ||
                       r_op == OP_SUB || r_op == OP_PASS);
        w_res_zero = !w_res_err && (w_alu_res == '0);
    end
`else
    always_comb begin
        w_res_err  = 1'b0;
        w_res_zero = (w_alu_res == '0);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_a      <= bus.req_a[32'(w_gnt_id) * WIDTH +: WIDTH];
                r_b      <= bus.req_b[32'(w_gnt_id) * WIDTH +: WIDTH];
                r_op     <= bus.req_op[32'(w_gnt_id) * OPW +: OPW];
                r_id     <= w_gnt_id;
                r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (r_state == S_EXEC) begin
                r_resp_valid  <= 1'b1;
                r_resp_id     <= r_id;
                r_resp_result <= w_alu_res;
                r_resp_zero   <= w_res_zero;
                r_resp_err    <= w_res_err;
            end else if (r_state == S_RESP && bus.resp_ready) begin
                r_resp_valid  <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_zero   = r_resp_zero;
    assign bus.resp_err    = r_resp_err;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: driver pushes expected responses,
// an independent monitor pops and compares on every accepted response.
module tb_alu_share_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned IDW   = 2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_ILL  = 4'b1111;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef ALU_SHARE_OPCHECK_EN
    localparam logic ILL_ZERO = 1'b0;
    localparam logic ILL_ERR  = 1'b1;
`else
    localparam logic ILL_ZERO = 1'b1;
    localparam logic ILL_ERR  = 1'b0;
`endif

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) u_bus ();

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [63:0] res, input logic z, input logic e);
        exp_t x;
        x.id     = IDW'(id);
        x.result = res;
        x.zero   = z;
        x.err    = e;
        return x;
    endfunction

    // Monitor: one comparison set per accepted response
    always @(negedge clk) begin
        if (reset === 1'b1 && u_bus.resp_valid === 1'b1 && u_bus.resp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual_id=%0d required=none", u_bus.resp_id);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_id",     64'(u_bus.resp_id),     64'(mon_e.id));
                chk("resp_result", u_bus.resp_result,      mon_e.result);
                chk("resp_zero",   64'(u_bus.resp_zero),   64'(mon_e.zero));
                chk("resp_err",    64'(u_bus.resp_err),    64'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        u_bus.req_a[id*WIDTH +: WIDTH] = a;
        u_bus.req_b[id*WIDTH +: WIDTH] = b;
        u_bus.req_op[id*4 +: 4]        = op;
        u_bus.req_valid[id]            = 1'b1;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_bus.req_ready != '0) begin
                g = u_bus.req_ready;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL grant_timeout actual=none required=grant at %0t", $time);
    endtask

    // Single request with latency check; resp_ready assumed high
    task automatic run_one(input int id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                           input logic [63:0] res, input logic z, input logic e);
        logic [NREQ-1:0] g;
        @(posedge clk); #1;
        set_req(id, a, b, op);
        wait_grant(g);
        chk("grant", 64'(g), 64'(1) << id);
        sb_q.push_back(mk(id, res, z, e));
        @(posedge clk); #1;
        u_bus.req_valid[id] = 1'b0;
        @(negedge clk);
        chk("exec_no_valid", 64'(u_bus.resp_valid), 64'(0));
        chk("exec_busy",     64'(u_bus.busy),       64'(1));
        @(negedge clk);
        chk("latency_valid", 64'(u_bus.resp_valid), 64'(1));
        @(negedge clk);
        chk("resp_drop",     64'(u_bus.resp_valid), 64'(0));
        chk("idle_busy",     64'(u_bus.busy),       64'(0));
    endtask

    initial begin
        logic [NREQ-1:0] g;
        time t_prev;
        time t_rdy;

        reset            = 1'b0;
        u_bus.req_valid  = '0;
        u_bus.req_a      = '0;
        u_bus.req_b      = '0;
        u_bus.req_op     = '0;
        u_bus.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready",   64'(u_bus.req_ready),   64'(0));
        chk("rst_resp_valid",  64'(u_bus.resp_valid),  64'(0));
        chk("rst_resp_id",     64'(u_bus.resp_id),     64'(0));
        chk("rst_resp_result", u_bus.resp_result,      64'(0));
        chk("rst_resp_zero",   64'(u_bus.resp_zero),   64'(0));
        chk("rst_resp_err",    64'(u_bus.resp_err),    64'(0));
        chk("rst_busy",        64'(u_bus.busy),        64'(0));

        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_req_ready",  64'(u_bus.req_ready),  64'(0));
            chk("idle_resp_valid", 64'(u_bus.resp_valid), 64'(0));
            chk("idle_busy0",      64'(u_bus.busy),       64'(0));
        end

        run_one(2, 64'd5, 64'd3, OP_ADD, 64'd8, 1'b0, 1'b0);
        run_one(0, 64'h1234, 64'h1234, OP_SUB, 64'd0, 1'b1, 1'b0);
        run_one(1, 64'd0, 64'd1, OP_SUB, ALL1, 1'b0, 1'b0);
        run_one(3, 64'hF0F0, 64'hFF00, OP_AND, 64'hF000, 1'b0, 1'b0);
        run_one(0, 64'hF0F0, 64'h0F0F, OP_OR, 64'hFFFF, 1'b0, 1'b0);
        run_one(1, 64'd5, 64'hDEAD, OP_PASS, 64'hDEAD, 1'b0, 1'b0);
        run_one(2, ALL1, 64'd1, OP_ADD, 64'd0, 1'b1, 1'b0);
        run_one(3, 64'd7, 64'd7, OP_ILL, 64'd0, ILL_ZERO, ILL_ERR);

        // Reset during EXEC discards the operation
        @(posedge clk); #1;
        set_req(2, 64'd1, 64'd1, OP_ADD);
        wait_grant(g);
        chk("pre_rst_grant", 64'(g), 64'b0100);
        @(posedge clk); #1;
        reset = 1'b0;
        u_bus.req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_exec_no_valid", 64'(u_bus.resp_valid), 64'(0));
            chk("rst_exec_busy",     64'(u_bus.busy),       64'(0));
        end

        // All requesters valid out of reset: order 0,1,2,3,0 every 3 cycles
        for (int i = 0; i < 4; i++) set_req(i, 64'(i + 1), 64'd10, OP_ADD);
        @(posedge clk); #1;
        reset  = 1'b1;
        t_prev = 0;
        for (int gi = 0; gi < 5; gi++) begin
            wait_grant(g);
            chk("rr_grant", 64'(g), 64'(1) << (gi % 4));
            sb_q.push_back(mk(gi % 4, 64'((gi % 4) + 11), 1'b0, 1'b0));
            if (gi > 0) chk("rr_spacing", 64'($time - t_prev), 64'd30);
            t_prev = $time;
        end
        @(posedge clk); #1;
        u_bus.req_valid = '0;
        repeat (4) @(negedge clk);

        // Backpressure: response held, no grants until resp_ready rises
        @(posedge clk); #1;
        u_bus.resp_ready = 1'b0;
        set_req(1, 64'd100, 64'd23, OP_ADD);
        wait_grant(g);
        chk("bp_grant", 64'(g), 64'b0010);
        sb_q.push_back(mk(1, 64'd123, 1'b0, 1'b0));
        @(posedge clk); #1;
        u_bus.req_valid[1] = 1'b0;
        set_req(3, 64'd9, 64'd6, OP_OR);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid",     64'(u_bus.resp_valid), 64'(1));
            chk("bp_id",        64'(u_bus.resp_id),    64'(1));
            chk("bp_result",    u_bus.resp_result,     64'd123);
            chk("bp_zero",      64'(u_bus.resp_zero),  64'(0));
            chk("bp_req_ready", 64'(u_bus.req_ready),  64'(0));
        end
        @(posedge clk); #1;
        u_bus.resp_ready = 1'b1;
        t_rdy = $time;
        wait_grant(g);
        chk("bp_next_grant", 64'(g), 64'b1000);
        chk("bp_grant_after_ready", 64'($time > t_rdy), 64'(1));
        sb_q.push_back(mk(3, 64'd15, 1'b0, 1'b0));
        @(posedge clk); #1;
        u_bus.req_valid[3] = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
